// File: rtl/subs_pipe.sv
// rtl/subs_pipe.sv - elastic pipelined signed subtractor with optional saturation
module subs_pipe #(
    parameter int W      = 8,
    parameter int STAGES = 2,
    parameter int SAT    = 0
) (
    input  logic         clk,
    input  logic         rst_b,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W:0]   diff,
    output logic         ovf,
    output logic         busy
);

    // Saturation bounds, already sign-extended to W+1 bits
    localparam logic [W:0] SAT_MAX = {2'b00, {(W-1){1'b1}}};
    localparam logic [W:0] SAT_MIN = {2'b11, {(W-1){1'b0}}};

    logic [STAGES-1:0] v_q, v_d;
    logic [STAGES-1:0] ovf_q, ovf_d;
    logic [W:0]        diff_q [STAGES];
    logic [W:0]        diff_d [STAGES];
    logic [STAGES-1:0] ready;

    logic [W:0] full;
    logic [W:0] res_diff;
    logic       res_ovf;

    // Full-precision difference; out of W-bit range exactly when the top two bits disagree
    always_comb begin
        full     = {a[W-1], a} - {b[W-1], b};
        res_diff = full;
        res_ovf  = 1'b0;
        if ((SAT != 0) && (full[W] != full[W-1])) begin
            res_ovf  = 1'b1;
            res_diff = full[W] ? SAT_MIN : SAT_MAX;
        end
    end

    // Bubble-collapsing ready chain, evaluated from the output back to the input
    always_comb begin
        ready = '0;
        ready[STAGES-1] = !v_q[STAGES-1] | out_ready;
        for (int i = STAGES - 2; i >= 0; i--) begin
            ready[i] = !v_q[i] | ready[i+1];
        end
    end

    // Each ready stage takes its upstream slot; an invalid slot only clears v and keeps old data
    always_comb begin
        v_d    = v_q;
        ovf_d  = ovf_q;
        diff_d = diff_q;
        if (ready[0]) begin
            v_d[0] = in_valid;
            if (in_valid) begin
                diff_d[0] = res_diff;
                ovf_d[0]  = res_ovf;
            end
        end
        for (int i = 1; i < STAGES; i++) begin
            if (ready[i]) begin
                v_d[i] = v_q[i-1];
                if (v_q[i-1]) begin
                    diff_d[i] = diff_q[i-1];
                    ovf_d[i]  = ovf_q[i-1];
                end
            end
        end
    end

    // Pipeline registers; reset discards everything in flight
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            v_q   <= '0;
            ovf_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                diff_q[i] <= '0;
            end
        end else begin
            v_q    <= v_d;
            ovf_q  <= ovf_d;
            diff_q <= diff_d;
        end
    end

    assign in_ready  = ready[0];
    assign out_valid = v_q[STAGES-1];
    assign diff      = diff_q[STAGES-1];
    assign ovf       = ovf_q[STAGES-1];
    assign busy      = |v_q;

endmodule

// File: tb/tb_subs_pipe.sv
// tb/tb_subs_pipe.sv - randomized scoreboard bench for subs_pipe over several depths
module tb_subs_pipe;

    localparam int W    = 8;
    localparam int NI   = 5;
    localparam int QD   = 8192;
    localparam int MAXV = 2 ** (W - 1) - 1;
    localparam int MINV = -(2 ** (W - 1));

    localparam int ST0 = 2, ST1 = 2, ST2 = 1, ST3 = 3, ST4 = 4;
    localparam int SA0 = 0, SA1 = 1, SA2 = 0, SA3 = 1, SA4 = 0;

    logic clk = 1'b0;
    logic rst_b;
    logic in_valid;
    logic out_ready;
    logic [W-1:0] a, b;

    logic [NI-1:0] in_ready_v, out_valid_v, ovf_v, busy_v;
    logic [W:0]    diff_v [NI];

    int stages_c [NI];
    int sat_c    [NI];

    int n_compared   = 0;
    int n_mismatched = 0;

    int exp_d [NI][QD];
    int exp_o [NI][QD];
    int exp_c [NI][QD];
    int wr [NI];
    int rd [NI];
    int base [NI];
    bit stall_prev [NI];
    int held_d [NI];
    int held_o [NI];
    int cyc = 0;
    bit exact_lat = 1'b0;
    int log0_d [16];
    int log1_d [16];
    int log1_o [16];
    int n_log0 = 0;
    int n_log1 = 0;
    int m_occ, m_idx;

    always #5 clk = ~clk;

    subs_pipe #(.W(W), .STAGES(ST0), .SAT(SA0)) u_p0 (
        .clk(clk), .rst_b(rst_b), .in_valid(in_valid), .in_ready(in_ready_v[0]),
        .a(a), .b(b), .out_valid(out_valid_v[0]), .out_ready(out_ready),
        .diff(diff_v[0]), .ovf(ovf_v[0]), .busy(busy_v[0]));
    subs_pipe #(.W(W), .STAGES(ST1), .SAT(SA1)) u_p1 (
        .clk(clk), .rst_b(rst_b), .in_valid(in_valid), .in_ready(in_ready_v[1]),
        .a(a), .b(b), .out_valid(out_valid_v[1]), .out_ready(out_ready),
        .diff(diff_v[1]), .ovf(ovf_v[1]), .busy(busy_v[1]));
    subs_pipe #(.W(W), .STAGES(ST2), .SAT(SA2)) u_p2 (
        .clk(clk), .rst_b(rst_b), .in_valid(in_valid), .in_ready(in_ready_v[2]),
        .a(a), .b(b), .out_valid(out_valid_v[2]), .out_ready(out_ready),
        .diff(diff_v[2]), .ovf(ovf_v[2]), .busy(busy_v[2]));
    subs_pipe #(.W(W), .STAGES(ST3), .SAT(SA3)) u_p3 (
        .clk(clk), .rst_b(rst_b), .in_valid(in_valid), .in_ready(in_ready_v[3]),
        .a(a), .b(b), .out_valid(out_valid_v[3]), .out_ready(out_ready),
        .diff(diff_v[3]), .ovf(ovf_v[3]), .busy(busy_v[3]));
    subs_pipe #(.W(W), .STAGES(ST4), .SAT(SA4)) u_p4 (
        .clk(clk), .rst_b(rst_b), .in_valid(in_valid), .in_ready(in_ready_v[4]),
        .a(a), .b(b), .out_valid(out_valid_v[4]), .out_ready(out_ready),
        .diff(diff_v[4]), .ovf(ovf_v[4]), .busy(busy_v[4]));

    task automatic check_eq(input string tag, input int got, input int exp);
        n_compared++;
        if (got != exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int ref_diff(input int av, input int bv, input int sat);
        int f;
        f = av - bv;
        if (sat != 0) begin
            if (f > MAXV) f = MAXV;
            else if (f < MINV) f = MINV;
        end
        return f;
    endfunction

    function automatic int ref_ovf(input int av, input int bv, input int sat);
        int f;
        f = av - bv;
        return ((sat != 0) && (f > MAXV || f < MINV)) ? 1 : 0;
    endfunction

    always @(posedge clk) cyc++;

    // Transaction-level scoreboard: a FIFO of expected results per instance
    always @(negedge clk) begin
        if (rst_b) begin
            for (int k = 0; k < NI; k++) begin
                m_occ = wr[k] - rd[k];
                check_eq($sformatf("busy_i%0d", k), int'(busy_v[k]), (m_occ != 0) ? 1 : 0);
                check_eq($sformatf("in_ready_i%0d", k), int'(in_ready_v[k]),
                         (m_occ == stages_c[k] && !out_ready) ? 0 : 1);
                if (stall_prev[k]) begin
                    check_eq($sformatf("hold_valid_i%0d", k), int'(out_valid_v[k]), 1);
                    check_eq($sformatf("hold_diff_i%0d", k), int'($signed(diff_v[k])), held_d[k]);
                    check_eq($sformatf("hold_ovf_i%0d", k), int'(ovf_v[k]), held_o[k]);
                end
                if (out_valid_v[k] && out_ready) begin
                    if (m_occ == 0) begin
                        check_eq($sformatf("pop_empty_i%0d", k), 1, 0);
                    end else begin
                        m_idx = rd[k] % QD;
                        check_eq($sformatf("diff_i%0d", k), int'($signed(diff_v[k])), exp_d[k][m_idx]);
                        check_eq($sformatf("ovf_i%0d", k), int'(ovf_v[k]), exp_o[k][m_idx]);
                        if (exact_lat)
                            check_eq($sformatf("latency_i%0d", k), cyc - exp_c[k][m_idx], stages_c[k]);
                        else
                            check_eq($sformatf("min_latency_i%0d", k),
                                     (cyc - exp_c[k][m_idx] >= stages_c[k]) ? 1 : 0, 1);
                        if (k == 0 && n_log0 < 16) begin
                            log0_d[n_log0] = int'($signed(diff_v[k]));
                            n_log0++;
                        end
                        if (k == 1 && n_log1 < 16) begin
                            log1_d[n_log1] = int'($signed(diff_v[k]));
                            log1_o[n_log1] = int'(ovf_v[k]);
                            n_log1++;
                        end
                        rd[k]++;
                    end
                end
                if (in_valid && in_ready_v[k]) begin
                    m_idx = wr[k] % QD;
                    exp_d[k][m_idx] = ref_diff(int'($signed(a)), int'($signed(b)), sat_c[k]);
                    exp_o[k][m_idx] = ref_ovf(int'($signed(a)), int'($signed(b)), sat_c[k]);
                    exp_c[k][m_idx] = cyc;
                    wr[k]++;
                end
                stall_prev[k] = out_valid_v[k] && !out_ready;
                held_d[k] = int'($signed(diff_v[k]));
                held_o[k] = int'(ovf_v[k]);
            end
        end
    end

    task automatic drive_pair(input int av, input int bv);
        a = 8'(av);
        b = 8'(bv);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bit empty;
        in_valid = 1'b0;
        out_ready = 1'b1;
        empty = 1'b0;
        for (int t = 0; t < 40 && !empty; t++) begin
            @(posedge clk);
            #1;
            empty = 1'b1;
            for (int k = 0; k < NI; k++) if (wr[k] != rd[k]) empty = 1'b0;
        end
        check_eq("drain_empty", int'(empty), 1);
        check_eq("drain_busy", int'(busy_v), 0);
    endtask

    initial begin
        int t1_a [5] = '{-1, -47, 115, -128, 127};
        int t1_b [5] = '{1, 29, -34, 127, -128};
        int t1_e [5] = '{-2, -76, 149, -255, 255};
        int t2_a [4] = '{127, -128, 100, -100};
        int t2_b [4] = '{-128, 1, -27, 28};
        int t2_e [4] = '{127, -128, 127, -128};
        int t2_o [4] = '{1, 1, 0, 0};
        int min_acc;
        int guard;

        stages_c = '{ST0, ST1, ST2, ST3, ST4};
        sat_c    = '{SA0, SA1, SA2, SA3, SA4};
        for (int k = 0; k < NI; k++) begin
            wr[k] = 0;
            rd[k] = 0;
            stall_prev[k] = 1'b0;
        end
        rst_b = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        a = '0;
        b = '0;

        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) begin
            check_eq($sformatf("rst_valid_i%0d", k), int'(out_valid_v[k]), 0);
            check_eq($sformatf("rst_busy_i%0d", k), int'(busy_v[k]), 0);
            check_eq($sformatf("rst_diff_i%0d", k), int'($signed(diff_v[k])), 0);
            check_eq($sformatf("rst_ovf_i%0d", k), int'(ovf_v[k]), 0);
        end
        rst_b = 1'b1;
        #1;
        for (int k = 0; k < NI; k++)
            check_eq($sformatf("post_rst_ready_i%0d", k), int'(in_ready_v[k]), 1);
        @(posedge clk);
        #1;

        // Back-to-back SAT=0 subtraction with exact latency
        exact_lat = 1'b1;
        n_log0 = 0;
        for (int i = 0; i < 5; i++) drive_pair(t1_a[i], t1_b[i]);
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check_eq("t1_count", n_log0, 5);
        for (int i = 0; i < 5; i++) check_eq($sformatf("t1_diff%0d", i), log0_d[i], t1_e[i]);

        // Saturation on the SAT=1 instance
        n_log1 = 0;
        for (int i = 0; i < 4; i++) drive_pair(t2_a[i], t2_b[i]);
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check_eq("t2_count", n_log1, 4);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("t2_diff%0d", i), log1_d[i], t2_e[i]);
            check_eq($sformatf("t2_ovf%0d", i), log1_o[i], t2_o[i]);
        end
        exact_lat = 1'b0;

        // Backpressure: only STAGES pairs fit, ready returns with out_ready
        out_ready = 1'b0;
        for (int k = 0; k < NI; k++) base[k] = wr[k];
        for (int i = 0; i < 6; i++)
            drive_pair(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128);
        for (int k = 0; k < NI; k++) begin
            check_eq($sformatf("bp_accepted_i%0d", k), wr[k] - base[k], stages_c[k]);
            check_eq($sformatf("bp_ready_low_i%0d", k), int'(in_ready_v[k]), 0);
        end
        out_ready = 1'b1;
        #1;
        for (int k = 0; k < NI; k++)
            check_eq($sformatf("bp_ready_same_cycle_i%0d", k), int'(in_ready_v[k]), 1);
        @(posedge clk);
        #1;
        drain();

        // Bubbles with offset out_ready pattern
        for (int i = 0; i < 40; i++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            in_valid = (i % 2) == 0;
            out_ready = (i % 3) != 1;
            @(posedge clk);
            #1;
        end
        drain();

        // Reset with pairs in flight
        out_ready = 1'b0;
        drive_pair(20, 5);
        drive_pair(-3, 9);
        in_valid = 1'b0;
        check_eq("mid_inflight", wr[0] - rd[0], 2);
        @(posedge clk);
        #2;
        rst_b = 1'b0;
        #1;
        check_eq("mid_rst_valid", int'(out_valid_v), 0);
        check_eq("mid_rst_busy", int'(busy_v), 0);
        for (int k = 0; k < NI; k++) begin
            rd[k] = wr[k];
            stall_prev[k] = 1'b0;
        end
        #1;
        rst_b = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        exact_lat = 1'b1;
        n_log0 = 0;
        drive_pair(10, 3);
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_eq("mid_count", n_log0, 1);
        check_eq("mid_diff", log0_d[0], 7);
        exact_lat = 1'b0;

        // Randomized sweep with random backpressure
        for (int k = 0; k < NI; k++) base[k] = wr[k];
        min_acc = 0;
        guard = 0;
        while (min_acc < 1000 && guard < 6000) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            in_valid = $urandom_range(0, 9) < 8;
            out_ready = $urandom_range(0, 9) < 7;
            @(posedge clk);
            #1;
            guard++;
            min_acc = wr[0] - base[0];
            for (int k = 1; k < NI; k++) if (wr[k] - base[k] < min_acc) min_acc = wr[k] - base[k];
        end
        check_eq("rand_reached_1000", (min_acc >= 1000) ? 1 : 0, 1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/subs_pipe.md
# subs_pipe

Pipelined signed subtractor with valid/ready handshakes on both sides. It computes `diff = a - b` at full precision, with optional saturation back to the input width. It is the inverse-direction counterpart of the combinational signed adder `addS`. It sits between a stimulus or producer stage and a consumer that may stall, and it carries operand pairs through a fixed-depth elastic pipeline.

## Interface
Parameters:
- `W`, 8, operand width in bits, two's complement, W ≥ 2.
- `STAGES`, 2, pipeline depth in registers, 1..4.
- `SAT`, 0. When 1, the result saturates to W bits; when 0, the result is the full W+1-bit difference.

Ports:
- `clk`, input, 1, clock, rising edge.
- `rst_b`, input, 1, reset, asynchronous, active-low.
- `in_valid`, input, 1, operand pair valid.
- `in_ready`, output, 1, block can accept an operand pair this cycle.
- `a`, input, W, signed minuend.
- `b`, input, W, signed subtrahend.
- `out_valid`, output, 1, result valid.
- `out_ready`, input, 1, consumer accepts the result this cycle.
- `diff`, output, W+1, signed result. When SAT=1, bit W equals bit W-1 (sign extension of the saturated W-bit value).
- `ovf`, output, 1, the saturated result differs from the true difference. Always 0 when SAT=0.
- `busy`, output, 1, at least one stage holds valid data.

## Operation
- Pipeline registers: `STAGES` registers S1..S_STAGES, each holding {v, diff, ovf}. The last register drives the outputs directly.
- The subtraction is done combinationally before S1:
  - `full = sext(a, W+1) - sext(b, W+1)`; this never overflows in W+1 bits.
  - SAT=0: `diff = full`, `ovf = 0`.
  - SAT=1:
    - `full > 2^(W-1)-1` gives `diff = 2^(W-1)-1`, `ovf = 1`.
    - `full < -2^(W-1)` gives `diff = -2^(W-1)`, `ovf = 1`.
    - Otherwise `diff = full`, `ovf = 0`.
- Per-stage advance rule (bubble-collapsing):
  - `ready_last = !v_last | out_ready`.
  - For each earlier stage, `ready_i = !v_i | ready_(i+1)`.
  - `in_ready = ready_1`.
- A stage loads from its upstream stage (or from the input for S1) when `ready_i` is high.
  - It loads `v = upstream valid`, plus the data fields.
  - When it loads an invalid slot, the data fields hold their old value. Only `v` clears.
- Input transfer: `in_valid & in_ready` in a cycle.
- Output transfer: `out_valid & out_ready`.
- `out_valid = v_last`. `busy` is the OR of all v.
- Results leave in strict input order. There is no loss and no duplication.
- Stall rules:
  - While `out_valid=1` and `out_ready=0`, `diff` and `ovf` hold stable.
  - An upstream bubble still advances into an empty downstream slot during a stall.
- `in_ready` is combinational from `out_ready` and the v bits. It does not depend on `in_valid`.

## Timing
- Reset (async assert, synchronous-safe deassert by the system):
  - All v bits = 0, all diff and ovf registers = 0.
  - Therefore `out_valid=0`, `diff=0`, `ovf=0`, `busy=0`.
  - `in_ready=1` as soon as reset deasserts.
- Latency: a pair accepted at edge N appears with `out_valid=1` after edge N+STAGES-1, i.e. visible in the cycle after `STAGES` registrations counted from the accepting edge. With STAGES=2 the result is visible two cycles after acceptance.
- Throughput: 1 pair per cycle while `out_ready=1`.
- Full pipeline: all v=1 and `out_ready=0` gives `in_ready=0`.
- Simultaneous drain and fill: all v=1 and `out_ready=1` gives `in_ready=1`. In that cycle the pipeline shifts, so input and output transfer together.
- Empty pipeline: `out_ready` is ignored and `out_valid=0`.
- Reset mid-operation: all in-flight data is discarded immediately. No partial result is emitted after reset.
- Capacity: at most STAGES pairs are in flight.

## Test plan
- **Reset and basic SAT=0 subtraction.** W=8, STAGES=2, SAT=0, `out_ready=1`. Drive reset, then send (a,b) = (-1,1), (-47,29), (115,-34), (-128,127), (127,-128) back-to-back.
  - Outputs 0 during reset, `in_ready=1` after.
  - `diff` = -2, -76, 149, -255, 255.
  - The first result appears 2 cycles after acceptance, then one per cycle, with `ovf=0`.
- **Saturation.** SAT=1, W=8. Send (127,-128), (-128,1), (100,-27), (-100,28).
  - `diff` = 127 with ovf=1, -128 with ovf=1, 127 with ovf=0, -128 with ovf=0.
- **Backpressure.** Hold `out_ready=0` with `in_valid=1` continuously.
  - Exactly STAGES pairs are accepted, then `in_ready=0`.
  - `diff` stays stable on the first result.
  - Raising `out_ready` drains the results in order. `in_ready` is high in the same cycle `out_ready` rises.
- **Bubbles.** Alternate `in_valid` 1/0 while `out_ready` toggles on a pattern offset from `in_valid`.
  - The scoreboard matches every result in order.
  - No output transfer occurs while `out_valid=0`.
- **Reset mid-stream.** With 2 pairs in flight, pulse `rst_b` low for a partial cycle.
  - `out_valid` and `busy` drop immediately, and the dropped pairs are never emitted.
  - The next pair, (10,3), yields 7 after 2 cycles.
- **Randomized sweep.** 1000 random signed pairs across W=8 and STAGES=1..4, with random `out_ready`.
  - Every result equals a - b, saturated when SAT=1.
  - `ovf` is set exactly when clipping occurs.
